// File: rtl/ahb_bus_arbiter.sv
`timescale 1ns/1ps
// ahb_bus_arbiter
// Round-robin arbiter sharing one AHB-to-APB bridge slave port between several
// AHB masters. Produces a registered one-hot grant and tracks the address-phase
// and data-phase owners that steer the external HADDR/HWDATA muxes. Fixed-length
// bursts, undefined-length INCR bursts and locked sequences are never broken.
// All registers advance only on edges where hready=1.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = 2
) (
    input  logic                   i_hclk,
    input  logic                   i_hresetn,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic [1:0]             i_htrans,
    input  logic [2:0]             i_hburst,
    input  logic                   i_hready,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [MW-1:0]          o_hmaster,
    output logic [MW-1:0]          o_hmaster_data,
    output logic                   o_hmastlock
);

    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,   // free arbitration on every accepted edge
        ST_BURST = 2'd1,   // fixed-length burst in progress, grant frozen
        ST_HOLD  = 2'd2,   // undefined-length INCR, frozen while owner requests
        ST_LOCK  = 2'd3    // locked sequence, frozen while owner holds hlock
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [MW-1:0]         r_rr_ptr;        // index of the current grant holder
    logic [MW-1:0]         w_ptr_next;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [NUM_MASTERS-1:0] w_hgrant_next;
    logic [MW-1:0]         r_hmaster;
    logic [MW-1:0]         r_hmaster_data;
    logic                  r_hmastlock;

    logic [MW-1:0]          w_winner;
    logic [NUM_MASTERS-1:0] w_owner_oh;
    logic [NUM_MASTERS-1:0] w_win_oh;
    int                     w_dist [NUM_MASTERS];
    int                     w_best;
    logic                   w_owner_granted;
    logic                   w_owner_req;
    logic                   w_gnt_lock;
    logic                   w_win_lock;
    logic                   w_start_burst;
    logic                   w_start_hold;
    logic [3:0]             w_burst_len_m1;

    // Per-master decode: search distance from the pointer, owner and winner one-hots,
    // and the one-hot form of the next grant.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            // distance 0 is the master right after the grant holder; the holder itself is last
            assign w_dist[gi]        = (gi + NUM_MASTERS - 1 - int'(r_rr_ptr)) % NUM_MASTERS;
            assign w_owner_oh[gi]    = (r_hmaster == MW'(gi));
            assign w_win_oh[gi]      = (w_winner == MW'(gi));
            assign w_hgrant_next[gi] = (w_ptr_next == MW'(gi));
        end
    endgenerate

    assign w_owner_granted = (r_hmaster == r_rr_ptr);
    assign w_owner_req     = |(i_hbusreq & w_owner_oh);
    assign w_gnt_lock      = |(i_hlock & r_hgrant);
    assign w_win_lock      = |(i_hlock & w_win_oh);
    assign w_start_burst   = (i_htrans == HTRANS_NONSEQ) && (i_hburst[2:1] != 2'b00);
    assign w_start_hold    = (i_htrans == HTRANS_NONSEQ) && (i_hburst == HBURST_INCR) && w_owner_req;

    // Round-robin pick: the requester closest after the current holder wins.
    always_comb begin
        w_winner = MW'(DEFAULT_MASTER);
        w_best   = NUM_MASTERS;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (i_hbusreq[i] && (w_dist[i] < w_best)) begin
                w_best   = w_dist[i];
                w_winner = MW'(i);
            end
        end
    end

    // Beats remaining after the NONSEQ of a 4/8/16-beat burst.
    always_comb begin
        w_burst_len_m1 = 4'd0;
        case (i_hburst[2:1])
            2'b01:   w_burst_len_m1 = 4'd3;
            2'b10:   w_burst_len_m1 = 4'd7;
            2'b11:   w_burst_len_m1 = 4'd15;
            default: w_burst_len_m1 = 4'd0;
        endcase
    end

    // Next state, beat count and grant holder for the coming accepted edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_rr_ptr;
        case (r_state)
            ST_ARB: begin
                if (w_owner_granted && (w_start_burst || w_start_hold)) begin
                    // keep the grant on the master starting the burst; lock wins
                    if (w_gnt_lock) begin
                        w_state_next = ST_LOCK;
                    end else if (w_start_burst) begin
                        w_state_next = ST_BURST;
                        w_cnt_next   = w_burst_len_m1;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end else begin
                    w_ptr_next   = w_winner;
                    w_state_next = w_win_lock ? ST_LOCK : ST_ARB;
                end
            end
            ST_BURST: begin
                if (i_htrans == HTRANS_SEQ) begin
                    if (r_cnt <= 4'd1) begin
                        // last beat: grant is released on the following accepted edge
                        w_cnt_next   = 4'd0;
                        w_state_next = ST_ARB;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end else if (i_htrans != HTRANS_BUSY) begin
                    // IDLE or NONSEQ mid-burst ends it early
                    w_cnt_next   = 4'd0;
                    w_state_next = ST_ARB;
                end
            end
            ST_HOLD: begin
                if (!w_owner_req) begin
                    w_ptr_next   = w_winner;
                    w_state_next = w_win_lock ? ST_LOCK : ST_ARB;
                end
            end
            ST_LOCK: begin
                if (!w_gnt_lock) begin
                    w_ptr_next   = w_winner;
                    w_state_next = w_win_lock ? ST_LOCK : ST_ARB;
                end
            end
            default: begin
                w_state_next = ST_ARB;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // FSM state, beat counter and grant register; frozen during wait states.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state  <= ST_ARB;
            r_cnt    <= 4'd0;
            r_rr_ptr <= MW'(DEFAULT_MASTER);
            r_hgrant <= GRANT_RST;
        end else if (i_hready) begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_rr_ptr <= w_ptr_next;
            r_hgrant <= w_hgrant_next;
        end
    end

    // Ownership pipeline: grant -> address owner -> data owner, plus lock flag.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_hmaster      <= MW'(DEFAULT_MASTER);
            r_hmaster_data <= MW'(DEFAULT_MASTER);
            r_hmastlock    <= 1'b0;
        end else if (i_hready) begin
            r_hmaster      <= r_rr_ptr;
            r_hmaster_data <= r_hmaster;
            r_hmastlock    <= w_gnt_lock;
        end
    end

    assign o_hgrant       = r_hgrant;
    assign o_hmaster      = r_hmaster;
    assign o_hmaster_data = r_hmaster_data;
    assign o_hmastlock    = r_hmastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
`timescale 1ns/1ps
// tb_ahb_bus_arbiter
// Directed stimulus for the round-robin AHB arbiter. Each step drives one cycle of
// inputs and pushes the expected post-edge outputs onto a scoreboard queue; a
// monitor pops and compares them just after the corresponding rising edge.
module tb_ahb_bus_arbiter;

    localparam int N  = 3;
    localparam int MW = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  hbusreq;
    logic [N-1:0]  hlock;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hready;
    logic [N-1:0]  hgrant;
    logic [MW-1:0] hmaster;
    logic [MW-1:0] hmaster_data;
    logic          hmastlock;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0),
        .MW             (MW)
    ) dut (
        .i_hclk         (clk),
        .i_hresetn      (rst_n),
        .i_hbusreq      (hbusreq),
        .i_hlock        (hlock),
        .i_htrans       (htrans),
        .i_hburst       (hburst),
        .i_hready       (hready),
        .o_hgrant       (hgrant),
        .o_hmaster      (hmaster),
        .o_hmaster_data (hmaster_data),
        .o_hmastlock    (hmastlock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic [2:0]  gnt;
        logic [1:0]  mst;
        logic [1:0]  mdat;
        logic        lock;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    // expected-state model: grant index, address owner, data owner, lock flag
    int   e_gidx = 0;
    int   e_mst  = 0;
    int   e_dat  = 0;
    logic e_lock = 1'b0;

    task automatic check(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] req, input logic [2:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready, input int gnt_after);
        exp_t e;
        hbusreq = req;
        hlock   = lock;
        htrans  = trans;
        hburst  = burst;
        hready  = ready;
        if (ready) begin
            e_dat  = e_mst;
            e_mst  = e_gidx;
            e_lock = lock[e_gidx];
            e_gidx = gnt_after;
        end
        e.due  = 32'(cyc + 1);
        e.gnt  = 3'b001 << e_gidx;
        e.mst  = 2'(e_mst);
        e.mdat = 2'(e_dat);
        e.lock = e_lock;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs shortly after each edge against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #3;
        if (sb_q.size() > 0 && sb_q[0].due == 32'(cyc)) begin
            e = sb_q.pop_front();
            $display("cyc %0d req=%b gnt=%b hmaster=%0d hdata=%0d hmastlock=%b",
                     cyc, hbusreq, hgrant, hmaster, hmaster_data, hmastlock);
            check("hgrant",       cyc, 8'(hgrant),       8'(e.gnt));
            check("hmaster",      cyc, 8'(hmaster),      8'(e.mst));
            check("hmaster_data", cyc, 8'(hmaster_data), 8'(e.mdat));
            check("hmastlock",    cyc, 8'(hmastlock),    8'(e.lock));
            check("onehot",       cyc, 8'($onehot(hgrant)), 8'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        hbusreq = '0;
        hlock   = '0;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hgrant",    cyc, 8'(hgrant),       8'h01);
        check("rst_hmaster",   cyc, 8'(hmaster),      8'h00);
        check("rst_hdata",     cyc, 8'(hmaster_data), 8'h00);
        check("rst_hmastlock", cyc, 8'(hmastlock),    8'h00);
        rst_n = 1'b1;

        // no requests: parked on master 0
        repeat (10) step(3'b000, 3'b000, IDLE, SINGLE, 1'b1, 0);

        // m1 and m2 requesting single transfers: alternate
        for (int k = 0; k < 6; k++)
            step(3'b110, 3'b000, NONSEQ, SINGLE, 1'b1, (k % 2 == 0) ? 1 : 2);

        // m1 INCR4 with m2 requesting and two wait states mid-burst
        step(3'b010, 3'b000, IDLE,   SINGLE, 1'b1, 1);
        step(3'b010, 3'b000, IDLE,   SINGLE, 1'b1, 1);
        step(3'b110, 3'b000, NONSEQ, INCR4,  1'b1, 1);
        step(3'b110, 3'b000, SEQ,    INCR4,  1'b1, 1);
        step(3'b110, 3'b000, SEQ,    INCR4,  1'b0, 1);
        step(3'b110, 3'b000, SEQ,    INCR4,  1'b0, 1);
        step(3'b110, 3'b000, SEQ,    INCR4,  1'b1, 1);
        step(3'b110, 3'b000, SEQ,    INCR4,  1'b1, 1);
        step(3'b100, 3'b000, IDLE,   SINGLE, 1'b1, 2);

        // m2 INCR8 cut short by IDLE after three beats, then m0 wins with lock
        step(3'b100, 3'b000, IDLE,   SINGLE, 1'b1, 2);
        step(3'b101, 3'b000, NONSEQ, INCR8,  1'b1, 2);
        step(3'b101, 3'b000, SEQ,    INCR8,  1'b1, 2);
        step(3'b101, 3'b000, SEQ,    INCR8,  1'b1, 2);
        step(3'b101, 3'b000, IDLE,   SINGLE, 1'b1, 2);
        step(3'b101, 3'b001, IDLE,   SINGLE, 1'b1, 0);

        // m0 locked for five transfers while m1, m2 request
        repeat (5) step(3'b111, 3'b001, NONSEQ, SINGLE, 1'b1, 0);
        step(3'b111, 3'b000, IDLE, SINGLE, 1'b1, 1);
        step(3'b111, 3'b000, IDLE, SINGLE, 1'b1, 2);

        // m1 undefined-length INCR holds the bus until it drops its request
        step(3'b010, 3'b000, IDLE,   SINGLE, 1'b1, 1);
        step(3'b010, 3'b000, IDLE,   SINGLE, 1'b1, 1);
        step(3'b111, 3'b000, NONSEQ, INCR,   1'b1, 1);
        step(3'b111, 3'b000, SEQ,    INCR,   1'b1, 1);
        step(3'b101, 3'b000, IDLE,   SINGLE, 1'b1, 2);

        // m2 INCR16, reset lands on beat 7
        step(3'b100, 3'b000, IDLE,   SINGLE, 1'b1, 2);
        step(3'b110, 3'b000, NONSEQ, INCR16, 1'b1, 2);
        repeat (5) step(3'b110, 3'b000, SEQ, INCR16, 1'b1, 2);
        #5;
        rst_n = 1'b0;
        #1;
        check("midrst_hgrant",    cyc, 8'(hgrant),       8'h01);
        check("midrst_hmaster",   cyc, 8'(hmaster),      8'h00);
        check("midrst_hdata",     cyc, 8'(hmaster_data), 8'h00);
        check("midrst_hmastlock", cyc, 8'(hmastlock),    8'h00);
        e_gidx = 0;
        e_mst  = 0;
        e_dat  = 0;
        e_lock = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // no burst survives reset: round robin restarts after master 0
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1, 1);
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1, 2);

        #5;
        check("sb_drain", cyc, 8'(sb_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
